// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// constant functions used to size counters.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software-reset request and sequenced reset outputs bundled between the
// sequencer (master) and the blocks it resets (slave).
interface reset_sequencer_if #(
   parameter int NUM_OUTS = 3
);
   logic                sw_rst_req;
   logic [NUM_OUTS-1:0] reset_sync;
   logic                rst_done;

   modport master (input sw_rst_req, output reset_sync, output rst_done);
   modport slave  (output sw_rst_req, input reset_sync, input rst_done);
endinterface

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert / synchronous-release flop chain; sync_ok rises on the
// STAGES-th clock edge after rst_n is released.
module reset_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_ok
);

   if (STAGES < 2) begin : g_bad_stages
      $error("reset_sync_chain: STAGES must be >= 2");
   end

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // shift a constant one toward the output
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], 1'b1};
   end

   // chain flops, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_ok = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes board reset release, stretches it, then
// releases NUM_OUTS reset domains in index order with a fixed gap.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 16,
   parameter int NUM_OUTS       = 3,
   parameter int STEP_CYCLES    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   reset_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, STEP_CYCLES) + 1);
   localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
   localparam logic [CNT_W-1:0]    STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0]    STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(NUM_OUTS - 1);
   localparam logic [NUM_OUTS-1:0] ALL_ON       = {NUM_OUTS{1'b1}};
   localparam logic [NUM_OUTS-1:0] ONE_HOT0     = NUM_OUTS'(1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("reset_sequencer: SYNC_STAGES must be >= 2");
   end
   if (STRETCH_CYCLES < 1) begin : g_bad_stretch
      $error("reset_sequencer: STRETCH_CYCLES must be >= 1");
   end
   if (NUM_OUTS < 1) begin : g_bad_outs
      $error("reset_sequencer: NUM_OUTS must be >= 1");
   end
   if (STEP_CYCLES < 1) begin : g_bad_step
      $error("reset_sequencer: STEP_CYCLES must be >= 1");
   end

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_OUTS-1:0] reset_sync_q, reset_sync_d;
   logic                rst_done_q, rst_done_d;
   logic                sync_ok;

   reset_sync_chain #(.STAGES(SYNC_STAGES)) u_chain (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_ok (sync_ok)
   );

   // next-state, counter and output computation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      reset_sync_d = reset_sync_q;
      rst_done_d   = rst_done_q;

      if (bus.sw_rst_req && (state_q != ST_HOLD)) begin
         state_d      = ST_STRETCH;
         cnt_d        = '0;
         idx_d        = '0;
         reset_sync_d = ALL_ON;
         rst_done_d   = 1'b0;
      end else begin
         case (state_q)
            // The clock that first sees sync_ok already counts as stretch clock 1.
            ST_HOLD, ST_STRETCH: begin
               if ((state_q == ST_STRETCH) || sync_ok) begin
                  if (cnt_q == STRETCH_LAST) begin
                     cnt_d        = '0;
                     reset_sync_d = ALL_ON & ~ONE_HOT0;
                     if (NUM_OUTS == 1) begin
                        state_d    = ST_DONE;
                        rst_done_d = 1'b1;
                     end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IDX_W'(1);
                     end
                  end else begin
                     cnt_d   = cnt_q + CNT_W'(1);
                     state_d = ST_STRETCH;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == STEP_LAST) begin
                  cnt_d        = '0;
                  reset_sync_d = reset_sync_q & ~(ONE_HOT0 << idx_q);
                  if (idx_q == IDX_LAST) begin
                     state_d    = ST_DONE;
                     rst_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               reset_sync_d = '0;
               rst_done_d   = 1'b1;
            end
            default: begin
               state_d      = ST_HOLD;
               cnt_d        = '0;
               idx_d        = '0;
               reset_sync_d = ALL_ON;
               rst_done_d   = 1'b0;
            end
         endcase
      end
   end

   // state and registered outputs; rst_n asserts everything without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         idx_q        <= '0;
         reset_sync_q <= ALL_ON;
         rst_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         reset_sync_q <= reset_sync_d;
         rst_done_q   <= rst_done_d;
      end
   end

   assign bus.reset_sync = reset_sync_q;
   assign bus.rst_done   = rst_done_q;

endmodule
